// File: rtl/word_serializer_16.sv
// Word serializer front-end for the 16:1 inverted-index bit mux.
// Holds an accepted word and steps sel 0..15 so the mux emits it MSB-first.
module word_serializer_16 #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        abort,
  output logic [15:0] word,
  output logic [3:0]  sel,
  output logic        bit_valid,
  output logic        bit_strobe,
  output logic        bit_last,
  output logic        busy,
  output logic        done
);

  if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 256) begin : g_bad_clks_per_bit
    $error("word_serializer_16: CLKS_PER_BIT must be in 1..256");
  end

  localparam logic [7:0] DIV_MAX = 8'(CLKS_PER_BIT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  div_q, div_d;
  logic        done_q, done_d;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    div_d   = div_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          sel_d   = 4'd0;
          div_d   = 8'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          // Cancelled word stays on word; only the sequencing is cleared.
          state_d = IDLE;
          sel_d   = 4'd0;
          div_d   = 8'd0;
        end else if (div_q < DIV_MAX) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = 8'd0;
          if (sel_q != 4'd15) begin
            sel_d = sel_q + 4'd1;
          end else begin
            state_d = IDLE;
            sel_d   = 4'd0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= IDLE;
      word_q  <= 16'h0;
      sel_q   <= 4'd0;
      div_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      div_q   <= div_d;
      done_q  <= done_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
  assign bit_valid  = (state_q == SHIFT);
  assign bit_strobe = (state_q == SHIFT) && (div_q == 8'd0);
  assign bit_last   = (state_q == SHIFT) && (sel_q == 4'd15);
  assign word       = word_q;
  assign sel        = sel_q;
  assign done       = done_q;

endmodule

// File: tb/tb_word_serializer_16.sv
// Directed bench for word_serializer_16 with CLKS_PER_BIT = 1, 3 and 2 instances
// sharing stimulus; each scenario checks one instance through the inverted-index mux.
module tb_word_serializer_16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        abort;

  logic        in_ready   [3];
  logic [15:0] word       [3];
  logic [3:0]  sel        [3];
  logic        bit_valid  [3];
  logic        bit_strobe [3];
  logic        bit_last   [3];
  logic        busy       [3];
  logic        done       [3];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  word_serializer_16 #(.CLKS_PER_BIT(1)) dut_c1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .abort(abort), .word(word[0]), .sel(sel[0]),
    .bit_valid(bit_valid[0]), .bit_strobe(bit_strobe[0]), .bit_last(bit_last[0]),
    .busy(busy[0]), .done(done[0])
  );

  word_serializer_16 #(.CLKS_PER_BIT(3)) dut_c3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .abort(abort), .word(word[1]), .sel(sel[1]),
    .bit_valid(bit_valid[1]), .bit_strobe(bit_strobe[1]), .bit_last(bit_last[1]),
    .busy(busy[1]), .done(done[1])
  );

  word_serializer_16 #(.CLKS_PER_BIT(2)) dut_c2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_data(in_data), .abort(abort), .word(word[2]), .sel(sel[2]),
    .bit_valid(bit_valid[2]), .bit_strobe(bit_strobe[2]), .bit_last(bit_last[2]),
    .busy(busy[2]), .done(done[2])
  );

  // 16:1 inverted-index mux: select 0 -> a[15], select 15 -> a[0].
  function automatic logic mux_out(int idx);
    logic [3:0] s;
    s = 4'd15 - sel[idx];
    return word[idx][s];
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(int idx);
    check("rst_word", 32'(word[idx]), 32'h0);
    check("rst_sel", 32'(sel[idx]), 32'd0);
    check("rst_in_ready", 32'(in_ready[idx]), 32'd1);
    check("rst_busy", 32'(busy[idx]), 32'd0);
    check("rst_bit_valid", 32'(bit_valid[idx]), 32'd0);
    check("rst_bit_strobe", 32'(bit_strobe[idx]), 32'd0);
    check("rst_bit_last", 32'(bit_last[idx]), 32'd0);
    check("rst_done", 32'(done[idx]), 32'd0);
  endtask

  // Offers data for one edge; on return the current cycle is the first bit cycle.
  task automatic send(int idx, logic [15:0] data);
    check("send_in_ready", 32'(in_ready[idx]), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    step();
    in_valid = 1'b0;
  endtask

  // Checks 16*cpb bit cycles, then the done cycle.
  task automatic serialize(int idx, logic [15:0] data, int cpb);
    for (int b = 0; b < 16; b++) begin
      for (int c = 0; c < cpb; c++) begin
        check("ser_out", 32'(mux_out(idx)), 32'(data[15-b]));
        check("ser_sel", 32'(sel[idx]), 32'(b));
        check("ser_busy", 32'(busy[idx]), 32'd1);
        check("ser_bit_valid", 32'(bit_valid[idx]), 32'd1);
        check("ser_in_ready", 32'(in_ready[idx]), 32'd0);
        check("ser_strobe", 32'(bit_strobe[idx]), 32'(c == 0));
        check("ser_last", 32'(bit_last[idx]), 32'(b == 15));
        check("ser_done", 32'(done[idx]), 32'd0);
        check("ser_word", 32'(word[idx]), 32'(data));
        step();
      end
    end
    check("end_done", 32'(done[idx]), 32'd1);
    check("end_in_ready", 32'(in_ready[idx]), 32'd1);
    check("end_bit_valid", 32'(bit_valid[idx]), 32'd0);
    check("end_sel", 32'(sel[idx]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 16'h0;
    abort    = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) check_reset_state(i);

    // 1. CLKS_PER_BIT=1, 16'hA5C3; done pulses for a single cycle.
    send(0, 16'hA5C3);
    serialize(0, 16'hA5C3, 1);
    step();
    check("t1_done_pulse_end", 32'(done[0]), 32'd0);

    // 2. CLKS_PER_BIT=3, 16'h8001: 48 busy cycles, 16 strobes.
    do_reset();
    send(1, 16'h8001);
    serialize(1, 16'h8001, 3);

    // 3. in_valid held with FFFF while busy on 0000; accepted in the done cycle.
    do_reset();
    send(0, 16'h0000);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    for (int k = 0; k < 16; k++) begin
      check("t3_in_ready", 32'(in_ready[0]), 32'd0);
      check("t3_out", 32'(mux_out(0)), 32'd0);
      check("t3_word", 32'(word[0]), 32'h0000);
      step();
    end
    check("t3_done", 32'(done[0]), 32'd1);
    check("t3_gap", 32'(bit_valid[0]), 32'd0);
    check("t3_ready_done", 32'(in_ready[0]), 32'd1);
    step();
    in_valid = 1'b0;
    serialize(0, 16'hFFFF, 1);

    // 4. abort while sel==5: back to IDLE, no done, word retained.
    do_reset();
    send(0, 16'h3C5A);
    for (int k = 0; k < 5; k++) step();
    check("t4_sel_before", 32'(sel[0]), 32'd5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_in_ready", 32'(in_ready[0]), 32'd1);
    check("t4_busy", 32'(busy[0]), 32'd0);
    check("t4_sel", 32'(sel[0]), 32'd0);
    check("t4_word", 32'(word[0]), 32'h3C5A);
    for (int k = 0; k < 20; k++) begin
      check("t4_no_done", 32'(done[0]), 32'd0);
      step();
    end

    // 5. reset while sel==9 on the CLKS_PER_BIT=2 instance, then 16'h1234.
    do_reset();
    send(2, 16'hF0F0);
    for (int k = 0; k < 18; k++) step();
    check("t5_sel_before", 32'(sel[2]), 32'd9);
    check("t5_busy_before", 32'(busy[2]), 32'd1);
    do_reset();
    check_reset_state(2);
    send(2, 16'h1234);
    serialize(2, 16'h1234, 2);

    // 6. in_valid with abort in IDLE: word is accepted.
    do_reset();
    check("t6_in_ready", 32'(in_ready[0]), 32'd1);
    in_valid = 1'b1;
    abort    = 1'b1;
    in_data  = 16'hC000;
    step();
    in_valid = 1'b0;
    abort    = 1'b0;
    serialize(0, 16'hC000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
